// File: rtl/gray_updown_counter.sv
// Up/down binary counter with a registered Gray-code mirror, zero and
// wrap flags, and a sticky checker that flags any count step whose Gray
// output changes by other than exactly one bit.
module gray_updown_counter #(
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] bin_o,
   output logic [WIDTH-1:0] gray_o,
   output logic             zero,
   output logic             wrap,
   output logic             chk_err
);

   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   logic [WIDTH-1:0] bin_step;
   logic [WIDTH-1:0] gray_step;
   logic [WIDTH-1:0] bin_nxt;
   logic [WIDTH-1:0] gray_diff;
   logic             step;
   logic             wrap_step;
   logic             step_ok;

   // Next binary value and the one-bit-change test on the stepped Gray code.
   // Gray is derived from the next binary value so both outputs update together.
   always_comb begin
      step      = en & ~load;
      bin_step  = dir ? (bin_o + ONE) : (bin_o - ONE);
      wrap_step = dir ? (bin_o == ALL_ONES) : (bin_o == '0);
      bin_nxt   = load ? load_val : (step ? bin_step : bin_o);
      gray_step = bin_step ^ (bin_step >> 1);
      gray_diff = gray_o ^ gray_step;
      step_ok   = (gray_diff != '0) && ((gray_diff & (gray_diff - ONE)) == '0);
   end

   // Output registers; chk_err is only updated on count steps and stays set until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_o   <= '0;
         gray_o  <= '0;
         zero    <= 1'b1;
         wrap    <= 1'b0;
         chk_err <= 1'b0;
      end else begin
         bin_o  <= bin_nxt;
         gray_o <= bin_nxt ^ (bin_nxt >> 1);
         zero   <= (bin_nxt == '0);
         wrap   <= step & wrap_step;
         if (step && !step_ok) begin
            chk_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gray_updown_counter.sv
// Scoreboard bench for gray_updown_counter at WIDTH=4: stimulus pushes the
// expected post-edge outputs, a monitor pops and compares after every edge.
module tb_gray_updown_counter;

   localparam int W    = 4;
   localparam int MAXV = 1 << W;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en = 1'b0;
   logic         dir = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] bin_o;
   logic [W-1:0] gray_o;
   logic         zero;
   logic         wrap;
   logic         chk_err;

   gray_updown_counter #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .dir      (dir),
      .load     (load),
      .load_val (load_val),
      .bin_o    (bin_o),
      .gray_o   (gray_o),
      .zero     (zero),
      .wrap     (wrap),
      .chk_err  (chk_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int    bin;
      int    gray;
      int    zero;
      int    wrap;
      string tag;
   } exp_t;

   exp_t q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   // reference state: plain integer count
   int   m_cnt  = 0;
   int   m_wrap = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want)
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      else
         n_pass++;
   endtask

   // reference model: one clock of the counter described arithmetically
   task automatic model_step(input bit r, input bit ld, input int lv, input bit e, input bit d);
      if (r) begin
         m_cnt = 0; m_wrap = 0;
      end else if (ld) begin
         m_cnt = lv; m_wrap = 0;
      end else if (e) begin
         if (d) begin
            m_wrap = (m_cnt + 1 == MAXV);
            m_cnt  = (m_cnt + 1) % MAXV;
         end else begin
            m_wrap = (m_cnt - 1 < 0);
            m_cnt  = (m_cnt - 1 + MAXV) % MAXV;
         end
      end else begin
         m_wrap = 0;
      end
   endtask

   task automatic apply(input bit r, input bit ld, input int lv, input bit e, input bit d);
      @(negedge clk);
      rst = r; load = ld; load_val = lv[W-1:0]; en = e; dir = d;
   endtask

   // cycle whose expectation comes from the reference model
   task automatic cyc(input string tag, input bit r, input bit ld, input int lv,
                      input bit e, input bit d);
      exp_t x;
      apply(r, ld, lv, e, d);
      model_step(r, ld, lv, e, d);
      x.bin = m_cnt; x.gray = m_cnt ^ (m_cnt >> 1);
      x.zero = (m_cnt == 0); x.wrap = m_wrap; x.tag = tag;
      q.push_back(x);
   endtask

   // cycle whose expectation is given literally
   task automatic cyc_x(input string tag, input bit r, input bit ld, input int lv,
                        input bit e, input bit d,
                        input int eb, input int eg, input int ez, input int ew);
      exp_t x;
      apply(r, ld, lv, e, d);
      model_step(r, ld, lv, e, d);
      x.bin = eb; x.gray = eg; x.zero = ez; x.wrap = ew; x.tag = tag;
      q.push_back(x);
   endtask

   // monitor: compare every output shortly after each rising edge
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk({e.tag, " bin_o"},   32'(bin_o),   32'(e.bin));
         chk({e.tag, " gray_o"},  32'(gray_o),  32'(e.gray));
         chk({e.tag, " zero"},    32'(zero),    32'(e.zero));
         chk({e.tag, " wrap"},    32'(wrap),    32'(e.wrap));
         chk({e.tag, " chk_err"}, 32'(chk_err), 32'd0);
      end
   end

   int up_gray [16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

   initial begin
      int wait_cyc;
      bit r, ld, e, d;
      int lv;

      cyc_x("reset", 1, 1, 9, 1, 1, 0, 0, 1, 0);

      for (int i = 0; i < 16; i++)
         cyc_x($sformatf("up%0d", i), 0, 0, 0, 1, 1,
               (i + 1) % 16, up_gray[i], (i == 15), (i == 15));

      cyc_x("down_wrap", 0, 0, 0, 1, 0, 15, 8, 0, 1);
      cyc_x("down_next", 0, 0, 0, 1, 0, 14, 9, 0, 0);

      cyc_x("load10", 0, 1, 10, 1, 1, 10, 15, 0, 0);
      cyc_x("after_load", 0, 0, 0, 1, 1, 11, 14, 0, 0);

      cyc_x("load6", 0, 1, 6, 0, 0, 6, 5, 0, 0);
      for (int i = 0; i < 5; i++)
         cyc_x($sformatf("hold%0d", i), 0, 0, 0, 0, 1, 6, 5, 0, 0);

      cyc_x("dir_up", 0, 0, 0, 1, 1, 7, 4, 0, 0);
      cyc_x("dir_down", 0, 0, 0, 1, 0, 6, 5, 0, 0);
      cyc_x("load0", 0, 1, 0, 1, 0, 0, 0, 1, 0);
      cyc_x("mid_up", 0, 0, 0, 1, 1, 1, 1, 0, 0);
      cyc_x("mid_rst", 1, 0, 0, 1, 1, 0, 0, 1, 0);
      cyc_x("post_rst", 0, 0, 0, 1, 1, 1, 1, 0, 0);

      for (int i = 0; i < 10000; i++) begin
         r  = ($urandom_range(63) == 0);
         ld = ($urandom_range(7) == 0);
         e  = ($urandom_range(3) != 0);
         d  = $urandom_range(1);
         lv = $urandom_range(MAXV - 1);
         cyc($sformatf("rand%0d", i), r, ld, lv, e, d);
      end

      @(negedge clk);
      rst = 0; load = 0; en = 0;
      wait_cyc = 0;
      while (q.size() > 0 && wait_cyc < 10) begin
         @(negedge clk);
         wait_cyc++;
      end
      chk("drain queue_left", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/gray_updown_counter.md
GRAY_UPDOWN_COUNTER -- requirements
Module: gray_updown_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 17: counter width in bits; legal range 2..32.
REQ-002 SHALL provide port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst, input, 1: synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL provide port en, input, 1: count enable.
REQ-005 SHALL provide port dir, input, 1: count direction; 1 = up, 0 = down.
REQ-006 SHALL provide port load, input, 1: synchronous load strobe.
REQ-007 SHALL provide port load_val, input, WIDTH: binary value to load.
REQ-008 SHALL provide port bin_o, output, WIDTH: registered binary count.
REQ-009 SHALL provide port gray_o, output, WIDTH: registered Gray code of bin_o, same cycle.
REQ-010 SHALL provide port zero, output, 1: registered; 1 when bin_o == 0.
REQ-011 SHALL provide port wrap, output, 1: registered one-cycle pulse on count wrap-around.
REQ-012 SHALL provide port chk_err, output, 1: sticky self-check error flag.

Function
REQ-013 Priority per cycle SHALL be rst > load > en > hold.
REQ-014 On load=1, bin_o SHALL take load_val, gray_o SHALL take load_val ^ (load_val >> 1), and wrap SHALL be 0, regardless of en and dir.
REQ-015 On en=1 and load=0, bin_o SHALL be incremented (dir=1) or decremented (dir=0) modulo 2^WIDTH.
REQ-016 gray_o SHALL always equal bin_o ^ (bin_o >> 1) in the same cycle, with zero lag between the two outputs.
REQ-017 wrap SHALL be 1 for exactly the cycle after an up-step from all-ones to 0, or a down-step from 0 to all-ones; otherwise it SHALL be 0.
REQ-018 On en=0 and load=0, bin_o, gray_o and zero SHALL hold, and wrap SHALL be 0.
REQ-019 zero SHALL reflect the updated bin_o in the same cycle, including after a load of 0.
REQ-020 A dir change between consecutive enabled cycles SHALL take effect immediately, with no dead cycle.
REQ-021 The internal checker SHALL compare the previous and next gray_o on every count step (en=1, load=0, rst=0).
REQ-022 The checker SHALL set chk_err when the Hamming distance between those two values is not exactly 1.
REQ-023 Load and hold cycles SHALL not be checked.
REQ-024 chk_err SHALL remain set until rst; with correct logic it never asserts.
REQ-025 All outputs SHALL be driven from flops; no combinational path from inputs to outputs.

Reset
REQ-026 While rst=1, the next edge SHALL give bin_o=0, gray_o=0, zero=1, wrap=0 and chk_err=0, overriding load and en.
REQ-027 Reset asserted mid-count SHALL take effect at the next edge with no partial update.
REQ-028 After reset, the first enabled step SHALL count from 0.

Verification (WIDTH=4)
REQ-029 Scenario: rst=1 for 1 cycle with load=1, load_val=9, en=1 -> bin_o=0, gray_o=0, zero=1, wrap=0, chk_err=0.
REQ-030 Scenario: from 0, en=1, dir=1 for 16 cycles -> gray_o sequence 1,3,2,6,7,5,4,12,13,15,14,10,11,9,8,0; wrap=1 only on the final (15->0) cycle; zero=1 only on that cycle.
REQ-031 Scenario: from 0, en=1, dir=0 for 1 cycle -> bin_o=15, gray_o=8, wrap=1; next down-step gives bin_o=14, gray_o=9, wrap=0.
REQ-032 Scenario: load=1, load_val=10, en=1, dir=1 -> bin_o=10, gray_o=15, wrap=0; next en cycle gives bin_o=11, gray_o=14.
REQ-033 Scenario: en=0 for 5 cycles at bin_o=6 -> bin_o=6 and gray_o=5 held, wrap=0 throughout.
REQ-034 Scenario: random en/dir/load for 10^4 cycles against a reference model -> outputs match every cycle, and chk_err stays 0.
